// File: rtl/uart_reg_writer.sv
// uart_reg_writer: UART byte receiver turning each valid byte into one register write; 8N1, or 8E1 when UART_PARITY_EN is defined
module uart_reg_writer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       frame_error,
  output logic       busy
);
  localparam logic [15:0] half_m1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] bit_m1 = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`ifdef UART_PARITY_EN
  localparam state_t after_data = PARITY;
`else
  localparam state_t after_data = STOP;
`endif
  state_t state;
  logic rx_m, rx_s, tick, par_ok;
  logic [15:0] timer;
  logic [3:0] count;
  logic [7:0] shreg;
`ifdef UART_PARITY_EN
  logic par;
  assign par_ok = ~(^shreg ^ par);
`else
  assign par_ok = 1'b1;
`endif
  assign tick = timer == 16'd0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      timer <= 16'd0;
      count <= 4'd0;
      shreg <= 8'd0;
      write_strobe <= 1'b0;
      frame_error <= 1'b0;
      address <= 3'd0;
      data <= 5'd0;
`ifdef UART_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      write_strobe <= 1'b0;
      frame_error <= 1'b0;
      timer <= tick ? bit_m1 : timer - 16'd1;
      case (state)
        IDLE: begin
          timer <= half_m1;
          if (!rx_s) state <= START;
        end
        START: if (tick) begin
          state <= rx_s ? IDLE : DATA;
          count <= 4'd0;
        end
        DATA: if (tick) begin
          shreg[count[2:0]] <= rx_s;
          count <= count + 4'd1;
          if (count == 4'd7) state <= after_data;
        end
`ifdef UART_PARITY_EN
        PARITY: if (tick) begin
          par <= rx_s;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          if (!rx_s) begin
            frame_error <= 1'b1;
            state <= WAIT_IDLE;
          end else if (!par_ok) begin
            frame_error <= 1'b1;
            state <= IDLE;
          end else begin
            write_strobe <= 1'b1;
            address <= shreg[2:0];
            data <= shreg[7:3];
            state <= IDLE;
          end
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_writer.sv
// tb_uart_reg_writer: randomized scoreboard bench for uart_reg_writer
module tb_uart_reg_writer;
  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    bit err;
    bit busy;
    logic [2:0] a;
    logic [4:0] d;
    int cyc;
  } ev_t;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic write_strobe, frame_error, busy;
  logic [2:0] address;
  logic [4:0] data;
  ev_t q[$];
  ev_t e_m;
  int cyc = 0, checks = 0, errors = 0;
  logic [2:0] last_a = 3'd0;
  logic [4:0] last_d = 5'd0;
  uart_reg_writer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .write_strobe(write_strobe),
    .address(address),
    .data(data),
    .frame_error(frame_error),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad_stop, input bit bad_par, input int low_extra);
    int n = cyc;
    logic [10:0] f;
    ev_t e;
`ifdef UART_PARITY_EN
    f = {~bad_stop, ^b ^ bad_par, b, 1'b0};
    e.err = bad_stop | bad_par;
`else
    f = {1'b1, ~bad_stop, b, 1'b0};
    e.err = bad_stop;
`endif
    e.busy = bad_stop;
    e.a = b[2:0];
    e.d = b[7:3];
    e.cyc = n + 2 + CPB / 2 + (NB - 1) * CPB + 1;
    q.push_back(e);
    for (int i = 0; i < NB; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (bad_stop) begin
      repeat (low_extra) @(posedge clk);
      #1;
      if (low_extra > 4) chk("busy_wait_idle", busy, 1);
    end
    rx = 1'b1;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      last_a = 3'd0;
      last_d = 5'd0;
    end else if (write_strobe || frame_error) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: strobe=%0b error=%0b, expected none (cycle %0d)", write_strobe, frame_error, cyc);
      end else begin
        e_m = q.pop_front();
        chk("event_kind", {write_strobe, frame_error}, e_m.err ? 1 : 2);
        chk("event_cycle", cyc, e_m.cyc);
        chk("busy_at_event", busy, e_m.busy);
        if (!e_m.err) begin
          last_a = e_m.a;
          last_d = e_m.d;
        end
        chk("address", address, last_a);
        chk("data", data, last_d);
      end
    end else begin
      chk("hold_address", address, last_a);
      chk("hold_data", data, last_d);
    end
  end
  initial begin
    logic [7:0] b;
    bit bs, bp;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    send(8'hA5, 1'b0, 1'b0, 0);
    repeat (20) @(posedge clk);
    #1;
    send(8'h3F, 1'b1, 1'b0, 30);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_after_wait_idle", busy, 0);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_glitch", busy, 1);
    rx = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("busy_after_glitch", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    send(8'h01, 1'b0, 1'b0, 0);
    send(8'hFE, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("busy_after_rst", busy, 0);
    repeat (200) @(posedge clk);
    #1;
`ifdef UART_PARITY_EN
    send(8'hA5, 1'b0, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    send(8'hA5, 1'b0, 1'b0, 0);
`endif
    for (int i = 0; i < 25; i++) begin
      b = 8'($urandom);
      bs = $urandom_range(5) == 0;
      bp = $urandom_range(5) == 0;
      send(b, bs, bp, bs ? int'($urandom_range(20)) : 0);
      repeat ((bs ? 2 : 0) + int'($urandom_range(6))) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_reg_writer.md
# uart_reg_writer

Serial front end for `signal_generator`. It receives 8N1 UART bytes on a single pin and turns each valid byte into one register write on the `write_strobe`/`address`/`data` bus that the generator consumes. This lets a host set up the generator over one wire instead of driving eight parallel inputs. Bit mapping matches the parallel path: byte[2:0] drives address and byte[7:3] drives data.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range 4..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  UART line, asynchronous to `clk`, idle high.
- `write_strobe`  out  1  one-cycle pulse; `address`/`data` are valid in that cycle.
- `address`  out  3  register address, held until the next accepted byte.
- `data`  out  5  register data, held until the next accepted byte.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer, giving `rx_s`. The sync flops reset to 1.
- The bit timer is a 16-bit down-counter. H = CLKS_PER_BIT/2, using integer division.
- The bit counter is 4 bits wide. The shift register is 8 bits, filled LSB first.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_s`==0, go to START and load the timer with H-1.
  - START: when the timer reaches 0, sample `rx_s`.
    - If the sample is 1, treat it as a glitch and return to IDLE with no output.
    - If the sample is 0, go to DATA with the timer set to CLKS_PER_BIT-1 and the bit count set to 0.
  - DATA: on each timer expiry, shift `rx_s` into bit[count] and reload the timer. After bit 7, go to STOP.
  - STOP: on timer expiry, sample `rx_s`.
    - If the sample is 1, commit the byte and return to IDLE.
    - If the sample is 0, pulse `frame_error` and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. This prevents a stuck-low line from being read as repeated start bits.
- On commit, in the same registered cycle:
  - `address` <= byte[2:0]
  - `data` <= byte[7:3]
  - `write_strobe` <= 1
- A rejected byte leaves `address`/`data` unchanged and does not assert `write_strobe`.
- Reset values:
  - FSM in IDLE; sync flops at 1.
  - `write_strobe`=0, `frame_error`=0, `busy`=0, `address`=0, `data`=0.

## Timing
- Let t0 be the first cycle in which `rx_s`==0 while in IDLE. `rx_s` lags `rx` by 2 cycles.
- Start sample: cycle t0+H.
- Data bit k (k=0..7) sample: cycle t0+H+(k+1)·CLKS_PER_BIT.
- Stop sample: cycle t0+H+9·CLKS_PER_BIT. `write_strobe` or `frame_error` is high in the following cycle, for exactly one cycle.
- `busy` rises the cycle after t0. It falls in the same cycle as `write_strobe`.
- IDLE is re-entered immediately after the stop sample, so a start edge at the following cycle is accepted. Back-to-back frames at full rate need no idle gap.
- `rst` asserted mid-frame:
  - Next cycle is the reset state; the partial byte is discarded.
  - No strobe or error is generated.
  - If the line is still low when `rst` deasserts, the sampler reads it as a start bit.
- `write_strobe` and `frame_error` are never high in the same cycle.

## Configuration
- `UART_PARITY_EN` undefined: 8N1 framing, exactly as described above.
- `UART_PARITY_EN` defined: 8E1 framing (8 data bits, even parity, 1 stop bit).
  - A PARITY state sits between DATA and STOP and samples at t0+H+9·CLKS_PER_BIT.
  - The stop sample moves to t0+H+10·CLKS_PER_BIT.
  - The frame is accepted only if (XOR of data bits ^ parity bit)==0 and the stop bit is 1.
  - A parity failure with a good stop bit pulses `frame_error` one cycle after the stop sample and returns to IDLE.
  - A bad stop bit goes to WAIT_IDLE, as in 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=16, 8N1 unless stated.
- Reset, then line idle-high for 100 cycles -> all outputs 0, `busy`=0.
- Send 0xA5 -> exactly one `write_strobe`, at t0+8+144+1. In that cycle `address`=5 and `data`=0x14. Values hold afterwards.
- Send 0x3F with stop bit driven 0 -> one `frame_error` pulse, no strobe, `address`/`data` keep their previous values, FSM in WAIT_IDLE until `rx` returns high.
- Drive `rx` low for 5 cycles, then high -> no strobe, no error, `busy` back to 0 at the start sample.
- Send 0x01 and 0xFE back-to-back with no gap -> two strobes 160 cycles apart, with (`address`,`data`)=(1,0) then (6,0x1F). Assert `rst` for 1 cycle mid-way through a third byte -> no third strobe.
- With `UART_PARITY_EN` defined, send 0xA5 with parity 0 -> strobe. Send 0xA5 with parity 1 -> `frame_error`, no strobe.
